// File: rtl/wb_pipeline.sv
// Write-back stage of the pipeline.
// This stage selects the write-back source, aligns and extends load data,
// and suppresses writes to r0. It registers the result and counts retired
// instructions. The load lane logic assumes NB_DATA >= 32.
module wb_pipeline #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_REG_ADDR = 5,
  parameter int unsigned NB_SELECTOR = 2,
  parameter int unsigned NB_COUNT    = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic [NB_DATA-1:0]     i_data_alu,
  input  logic [NB_DATA-1:0]     i_data_mem,
  input  logic [NB_DATA-1:0]     i_pc_plus4,
  input  logic [NB_SELECTOR-1:0] i_selector,
  input  logic [1:0]             i_load_size,
  input  logic                   i_load_unsigned,
  input  logic [1:0]             i_byte_offset,
  input  logic                   i_reg_write,
  input  logic [NB_REG_ADDR-1:0] i_reg_addr,
  output logic [NB_DATA-1:0]     o_data,
  output logic [NB_REG_ADDR-1:0] o_reg_addr,
  output logic                   o_reg_write,
  output logic                   o_valid,
  output logic [NB_COUNT-1:0]    o_retired_count
);

  localparam logic [NB_SELECTOR-1:0] SEL_ALU = NB_SELECTOR'(0);
  localparam logic [NB_SELECTOR-1:0] SEL_MEM = NB_SELECTOR'(1);
  localparam logic [NB_SELECTOR-1:0] SEL_PC4 = NB_SELECTOR'(2);

  logic [7:0]             byte_lane;
  logic [15:0]            half_lane;
  logic                   ext_bit;
  logic [NB_DATA-1:0]     load_data;
  logic [NB_DATA-1:0]     wb_data;

  logic [NB_DATA-1:0]     data_q,      data_d;
  logic [NB_REG_ADDR-1:0] reg_addr_q,  reg_addr_d;
  logic                   reg_write_q, reg_write_d;
  logic                   valid_q,     valid_d;
  logic [NB_COUNT-1:0]    count_q,     count_d;

  // Load alignment: pick the addressed byte/half lane and sign- or zero-extend it.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    byte_lane = i_data_mem[7:0];
    half_lane = i_data_mem[15:0];
    ext_bit   = 1'b0;
    load_data = i_data_mem;
    case (i_byte_offset)
      2'd0:    byte_lane = i_data_mem[7:0];
      2'd1:    byte_lane = i_data_mem[15:8];
      2'd2:    byte_lane = i_data_mem[23:16];
      default: byte_lane = i_data_mem[31:24];
    endcase
    if (i_byte_offset[1]) half_lane = i_data_mem[31:16];
    case (i_load_size)
      2'b00: begin
        ext_bit   = ~i_load_unsigned & byte_lane[7];
        load_data = {{(NB_DATA-8){ext_bit}}, byte_lane};
      end
      2'b01: begin
        ext_bit   = ~i_load_unsigned & half_lane[15];
        load_data = {{(NB_DATA-16){ext_bit}}, half_lane};
      end
      default: load_data = i_data_mem;
    endcase
  end

  // Write-back source select; load controls only matter for the MEM source.
  always_comb begin
    wb_data = '0;
    case (i_selector)
      SEL_ALU: wb_data = i_data_alu;
      SEL_MEM: wb_data = load_data;
      SEL_PC4: wb_data = i_pc_plus4;
      default: wb_data = '0;
    endcase
  end

  // Next-state for the output registers: flush squashes and wins over stall; stall holds.
  always_comb begin
    data_d      = data_q;
    reg_addr_d  = reg_addr_q;
    reg_write_d = reg_write_q;
    valid_d     = valid_q;
    count_d     = count_q;
    if (i_flush) begin
      data_d      = '0;
      reg_addr_d  = '0;
      reg_write_d = 1'b0;
      valid_d     = 1'b0;
    end else if (!i_stall) begin
      data_d      = wb_data;
      reg_addr_d  = i_reg_addr;
      reg_write_d = i_valid & i_reg_write & (i_reg_addr != '0);
      valid_d     = i_valid;
      count_d     = count_q + NB_COUNT'(i_valid);
    end
  end

  // Output and counter registers; synchronous reset overrides flush and stall.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is written with <= so all registers update from pre-edge values.
    if (i_reset) begin
      data_q      <= '0;
      reg_addr_q  <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      data_q      <= data_d;
      reg_addr_q  <= reg_addr_d;
      reg_write_q <= reg_write_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
    end
  end

  assign o_data          = data_q;
  assign o_reg_addr      = reg_addr_q;
  assign o_reg_write     = reg_write_q;
  assign o_valid         = valid_q;
  assign o_retired_count = count_q;

endmodule

// File: tb/tb_wb_pipeline.sv
// Scoreboard bench for wb_pipeline.
// The driver predicts each cycle's registered outputs from a behavioural
// model and queues them. The monitor pops one prediction after every edge
// and compares it with the outputs.
module tb_wb_pipeline;

  localparam int NB_COUNT = 4;
  localparam int CMASK    = (1 << NB_COUNT) - 1;

  typedef struct {
    logic        rst, valid, stall, flush;
    logic [31:0] alu, mem, pc4;
    logic [1:0]  sel, size, off;
    logic        uns, rw;
    logic [4:0]  addr;
  } stim_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we, valid;
    int          cnt;
    bit          data_chk;
    bit          addr_chk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset, i_valid, i_stall, i_flush;
  logic [31:0] i_data_alu, i_data_mem, i_pc_plus4;
  logic [1:0]  i_selector, i_load_size, i_byte_offset;
  logic        i_load_unsigned, i_reg_write;
  logic [4:0]  i_reg_addr;
  logic [31:0] o_data;
  logic [4:0]  o_reg_addr;
  logic        o_reg_write, o_valid;
  logic [NB_COUNT-1:0] o_retired_count;

  wb_pipeline #(.NB_DATA(32), .NB_REG_ADDR(5), .NB_SELECTOR(2), .NB_COUNT(NB_COUNT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_data_alu(i_data_alu), .i_data_mem(i_data_mem), .i_pc_plus4(i_pc_plus4),
    .i_selector(i_selector), .i_load_size(i_load_size), .i_load_unsigned(i_load_unsigned),
    .i_byte_offset(i_byte_offset), .i_reg_write(i_reg_write), .i_reg_addr(i_reg_addr),
    .o_data(o_data), .o_reg_addr(o_reg_addr), .o_reg_write(o_reg_write), .o_valid(o_valid),
    .o_retired_count(o_retired_count)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t m;  // model of the registered state

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Load value computed arithmetically: shift the lane down, mask, subtract 2^n for negatives.
  function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
    longint v;
    if (size >= 2) return mem;
    if (size == 0) begin
      v = (longint'(mem) >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else begin
      v = (longint'(mem) >> (16 * off[1])) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wb(input stim_t s);
    case (s.sel)
      2'd0:    return s.alu;
      2'd1:    return ref_load(s.mem, s.size, s.uns, s.off);
      2'd2:    return s.pc4;
      default: return 32'd0;
    endcase
  endfunction

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic apply(input stim_t s);
    @(negedge clk);
    i_reset = s.rst; i_valid = s.valid; i_stall = s.stall; i_flush = s.flush;
    i_data_alu = s.alu; i_data_mem = s.mem; i_pc_plus4 = s.pc4;
    i_selector = s.sel; i_load_size = s.size; i_load_unsigned = s.uns;
    i_byte_offset = s.off; i_reg_write = s.rw; i_reg_addr = s.addr;
    if (s.rst) begin
      m = '{data: 0, addr: 0, we: 0, valid: 0, cnt: 0, data_chk: 1, addr_chk: 1};
    end else if (s.flush) begin
      m.data = 0; m.addr = 0; m.we = 0; m.valid = 0; m.data_chk = 1; m.addr_chk = 1;
    end else if (!s.stall) begin
      m.valid    = s.valid;
      m.we       = s.valid && s.rw && (s.addr != 0);
      m.data     = ref_wb(s);
      m.addr     = s.addr;
      m.data_chk = s.valid;
      m.addr_chk = s.valid;
      if (s.valid) m.cnt = (m.cnt + 1) & CMASK;
    end
    exp_q.push_back(m);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 0, valid: 0, stall: 0, flush: 0, alu: 0, mem: 0, pc4: 0,
          sel: 0, size: 0, off: 0, uns: 0, rw: 0, addr: 0};
    return s;
  endfunction

  function automatic stim_t instr(input logic [1:0] sel, input logic [31:0] alu,
                                  input logic [31:0] mem, input logic [31:0] pc4,
                                  input logic [1:0] size, input logic uns,
                                  input logic [1:0] off, input logic [4:0] addr);
    stim_t s;
    s = idle();
    s.valid = 1; s.rw = 1; s.sel = sel; s.alu = alu; s.mem = mem; s.pc4 = pc4;
    s.size = size; s.uns = uns; s.off = off; s.addr = addr;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = ($urandom_range(0, 49) == 0);
    s.valid = ($urandom_range(0, 3) != 0);
    s.stall = ($urandom_range(0, 5) == 0);
    s.flush = ($urandom_range(0, 9) == 0);
    s.alu = $urandom; s.mem = $urandom; s.pc4 = $urandom;
    s.sel = 2'($urandom_range(0, 3)); s.size = 2'($urandom_range(0, 3));
    s.off = 2'($urandom_range(0, 3)); s.uns = 1'($urandom_range(0, 1));
    s.rw  = 1'($urandom_range(0, 1)); s.addr = 5'($urandom_range(0, 31));
    return s;
  endfunction

  // Monitor: after each edge, pop the prediction for it and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("valid", {31'd0, o_valid}, {31'd0, e.valid});
        check("reg_write", {31'd0, o_reg_write}, {31'd0, e.we});
        check("count", {{(32-NB_COUNT){1'b0}}, o_retired_count}, 32'(e.cnt));
        if (e.data_chk) check("data", o_data, e.data);
        if (e.addr_chk) check("reg_addr", {27'd0, o_reg_addr}, {27'd0, e.addr});
      end
    end
  end

  initial begin
    stim_t s;
    m = '{data: 0, addr: 0, we: 0, valid: 0, cnt: 0, data_chk: 0, addr_chk: 0};
    i_reset = 1; i_valid = 0; i_stall = 0; i_flush = 0;
    i_data_alu = 0; i_data_mem = 0; i_pc_plus4 = 0; i_selector = 0;
    i_load_size = 0; i_load_unsigned = 0; i_byte_offset = 0; i_reg_write = 0; i_reg_addr = 0;

    // Reset state.
    s = idle(); s.rst = 1; apply(s); apply(s);

    // ALU path, count reaches 1.
    apply(instr(2'd0, 32'h12345678, 0, 0, 2'd0, 0, 2'd0, 5'd5));
    // Byte loads.
    apply(instr(2'd1, 0, 32'h80FF7F01, 0, 2'd0, 0, 2'd3, 5'd6));
    apply(instr(2'd1, 0, 32'h80FF7F01, 0, 2'd0, 1, 2'd3, 5'd7));
    apply(instr(2'd1, 0, 32'h80FF7F01, 0, 2'd0, 0, 2'd1, 5'd8));
    // Half loads, including the ignored low offset bit.
    apply(instr(2'd1, 0, 32'h8001ABCD, 0, 2'd1, 0, 2'd0, 5'd9));
    apply(instr(2'd1, 0, 32'h8001ABCD, 0, 2'd1, 1, 2'd3, 5'd10));
    // Word load ignores offset and extension.
    apply(instr(2'd1, 0, 32'h8001ABCD, 0, 2'd2, 0, 2'd3, 5'd11));
    // Load controls ignored outside MEM; select 11 yields zero.
    apply(instr(2'd0, 32'hCAFEF00D, 32'h80FF7F01, 0, 2'd0, 0, 2'd3, 5'd12));
    apply(instr(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 0, 2'd0, 5'd13));
    // Link to r0: data passes, write suppressed.
    apply(instr(2'd2, 0, 0, 32'h40, 2'd0, 0, 2'd0, 5'd0));
    // Bubble.
    apply(idle());

    // Stall plus flush together: squashed, count unchanged.
    apply(instr(2'd0, 32'h11, 0, 0, 2'd0, 0, 2'd0, 5'd3));
    s = instr(2'd0, 32'h22, 0, 0, 2'd0, 0, 2'd0, 5'd4); s.stall = 1; s.flush = 1; apply(s);
    // Stall alone for three cycles with changing inputs: outputs frozen.
    apply(instr(2'd0, 32'h33, 0, 0, 2'd0, 0, 2'd0, 5'd14));
    for (int i = 0; i < 3; i++) begin
      s = instr(2'd0, 32'hA0 + 32'(i), 0, 0, 2'd0, 0, 2'd0, 5'(20 + i)); s.stall = 1; apply(s);
    end
    // Reset during a stall clears everything; first instruction afterwards counts 1.
    s = idle(); s.stall = 1; s.rst = 1; apply(s);
    apply(instr(2'd0, 32'h55, 0, 0, 2'd0, 0, 2'd0, 5'd15));

    // Counter wrap: 17 consecutive valid instructions from reset.
    s = idle(); s.rst = 1; apply(s);
    for (int i = 0; i < 17; i++)
      apply(instr(2'd0, 32'(i), 0, 0, 2'd0, 0, 2'd0, 5'd1));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) apply(rand_stim());

    s = idle(); apply(s);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_pipeline.md
WB_PIPELINE -- requirements
Module: wb_pipeline

Interface
REQ-001 Parameter NB_DATA, default 32, data path width in bits.
REQ-002 Parameter NB_REG_ADDR, default 5, register-file address width.
REQ-003 Parameter NB_SELECTOR, default 2, write-back source selector width.
REQ-004 Parameter NB_COUNT, default 32, retired-instruction counter width.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  the MEM/WB input holds a real instruction.
- i_stall  input  1  hold all pipeline registers.
- i_flush  input  1  squash the incoming instruction.
- i_data_alu  input  NB_DATA  ALU result.
- i_data_mem  input  NB_DATA  raw memory read word.
- i_pc_plus4  input  NB_DATA  link address (JAL/JALR).
- i_selector  input  NB_SELECTOR  source: 00 ALU, 01 MEM, 10 PC+4, 11 zero.
- i_load_size  input  2  load size: 00 byte, 01 half, 10/11 word.
- i_load_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
- i_byte_offset  input  2  load address bits [1:0].
- i_reg_write  input  1  the instruction writes the register file.
- i_reg_addr  input  NB_REG_ADDR  destination register.
- o_data  output  NB_DATA  registered write-back data.
- o_reg_addr  output  NB_REG_ADDR  registered destination register.
- o_reg_write  output  1  registered register-file write enable.
- o_valid  output  1  registered instruction-valid flag.
- o_retired_count  output  NB_COUNT  count of retired valid instructions.

Function
REQ-006 All outputs SHALL be registered; latency is exactly 1 cycle from an input sample to the output.
REQ-007 Source select for MEM (01) SHALL apply load extraction per REQ-008..REQ-010; select 11 SHALL yield all zeros.
REQ-008 Byte load: lane = i_byte_offset (0 = bits[7:0] ... 3 = bits[31:24]), extended to NB_DATA per i_load_unsigned.
REQ-009 Half load: lane = i_byte_offset[1] (0 = bits[15:0], 1 = bits[31:16]); i_byte_offset[0] ignored (no misalignment trap); extended per i_load_unsigned.
REQ-010 Word load: i_data_mem passed unchanged; i_byte_offset and i_load_unsigned ignored.
REQ-011 i_load_size, i_load_unsigned and i_byte_offset SHALL have no effect when i_selector != 01.
REQ-012 o_reg_write SHALL be captured as i_valid & i_reg_write & (i_reg_addr != 0); writes to r0 are always suppressed.
REQ-013 When i_stall = 1 and i_flush = 0, all output registers and the counter SHALL hold their values.
REQ-014 When i_flush = 1, the cycle SHALL capture o_valid = 0 and o_reg_write = 0, with o_data and o_reg_addr cleared to 0; flush takes priority over stall.
REQ-015 o_retired_count SHALL increment by 1 on each edge that captures i_valid = 1 (not stalled, not flushed, not in reset).
REQ-016 o_retired_count SHALL wrap from 2^NB_COUNT-1 to 0 without any flag.
REQ-017 An i_valid = 0 bubble SHALL propagate as o_valid = 0 and o_reg_write = 0; o_data is don't-care.

Reset
REQ-018 While i_reset = 1 at a rising edge, all outputs including o_retired_count SHALL become 0; reset takes priority over flush and stall.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight instruction; the first valid input after reset deasserts SHALL appear one cycle later with the counter at 1.

Verification
REQ-020 ALU path: sel=00, alu=0x12345678, valid, reg_write, addr=5 -> next cycle o_data=0x12345678, o_reg_addr=5, o_reg_write=1, o_valid=1, count=1.
REQ-021 Byte loads: mem=0x80FF7F01, size=00, offset=3, signed -> 0xFFFFFF80; the same with unsigned -> 0x00000080; offset=1, signed -> 0x0000007F.
REQ-022 Half loads: mem=0x8001ABCD, size=01, offset=0, signed -> 0xFFFFABCD; offset=3, unsigned -> 0x00008001.
REQ-023 r0 and link: sel=10, pc_plus4=0x40, addr=0, reg_write=1 -> o_data=0x40, o_reg_write=0, o_valid=1.
REQ-024 Stall/flush: stall and flush asserted together -> o_valid=0, count unchanged; stall alone for 3 cycles -> outputs frozen; reset during a stall -> all outputs 0.
REQ-025 Wrap: NB_COUNT=4, 17 consecutive valid instructions -> count sequence reaches 15, then 0, then 1.
